// File: rtl/clk_pattern_pkg.sv
// Shared types and defaults for the clock pattern generator.
//   state_t   : sequencer states (IDLE / RUN / STOP)
//   DEF_N_CH  : default number of generated clock channels
//   DEF_PAT_W : default maximum pattern length in bits
package clk_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int unsigned DEF_N_CH  = 2;
    localparam int unsigned DEF_PAT_W = 16;

endpackage

// File: rtl/pattern_lane.sv
// One generated-clock channel: shadow and active pattern registers plus the
// registered bit select that drives the channel's clock output.
//   clk, rstn  : source clock, async active-low reset
//   stage_i    : capture pat_i into the shadow register
//   apply_i    : copy shadow into the active register (frame boundary / idle)
//   play_i     : sequencer is not idle; when low the output is forced to 0
//   pat_i      : pattern for this channel, bit 0 played first
//   cnt_i      : current bit position within the frame
//   gen_clk_o  : registered generated clock
module pattern_lane
    import clk_pattern_pkg::*;
#(
    parameter int unsigned  PAT_W = DEF_PAT_W,
    localparam int unsigned CW    = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stage_i,
    input  logic             apply_i,
    input  logic             play_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [CW-1:0]    cnt_i,
    output logic             gen_clk_o
);

    logic [PAT_W-1:0] shadow_q;
    logic [PAT_W-1:0] active_q;
    logic             gen_clk_q;

    // The output bit is taken from the active register as it stood before
    // this edge, so an apply on the wrap edge only affects the next frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q  <= '0;
            active_q  <= '0;
            gen_clk_q <= 1'b0;
        end else begin
            if (stage_i) shadow_q <= pat_i;
            if (apply_i) active_q <= shadow_q;
            gen_clk_q <= play_i & active_q[cnt_i];
        end
    end

    assign gen_clk_o = gen_clk_q;

endmodule

// File: rtl/clk_pattern_gen.sv
// Multi-channel programmable clock pattern generator. Each channel replays a
// pattern of pat_len+1 bits, one per clk cycle. New patterns are staged in a
// shadow and applied only at a frame boundary (or immediately while idle).
//   clk, rstn     : source clock, async active-low reset
//   en_i          : run request (level)
//   load_i        : single-cycle request to stage pat_in_i / pat_len_i
//   pat_in_i      : channel c pattern in bits [c*PAT_W +: PAT_W]
//   pat_len_i     : frame length minus 1
//   gen_clk_o     : registered generated clocks
//   frame_sync_o  : high while gen_clk_o shows bit 0
//   load_pend_o   : a staged pattern is waiting to be applied
//   load_ovf_o    : one-cycle pulse, a load was dropped
//   running_o     : sequencer is in RUN
module clk_pattern_gen
    import clk_pattern_pkg::*;
#(
    parameter int unsigned  N_CH  = DEF_N_CH,
    parameter int unsigned  PAT_W = DEF_PAT_W,
    localparam int unsigned CW    = $clog2(PAT_W)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en_i,
    input  logic                  load_i,
    input  logic [N_CH*PAT_W-1:0] pat_in_i,
    input  logic [CW-1:0]         pat_len_i,
    output logic [N_CH-1:0]       gen_clk_o,
    output logic                  frame_sync_o,
    output logic                  load_pend_o,
    output logic                  load_ovf_o,
    output logic                  running_o
);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] len_act_q;
    logic [CW-1:0] len_shd_q;
    logic          load_pend_q;
    logic          load_pend_d;
    logic          load_ovf_q;
    logic          frame_sync_q;
    logic          running_q;

    logic          play;
    logic          wrap;
    logic          apply;
    logic          stage;

    // A load arriving on the same edge the pending shadow is consumed is
    // accepted, so the pending flag stays set for the new data.
    always_comb begin
        play        = (state_q != ST_IDLE);
        wrap        = play && (cnt_q == len_act_q);
        apply       = load_pend_q && (!play || wrap);
        stage       = load_i && (!load_pend_q || apply);
        load_pend_d = stage || (load_pend_q && !apply);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            len_act_q    <= CW'(PAT_W - 1);
            len_shd_q    <= '0;
            load_pend_q  <= 1'b0;
            load_ovf_q   <= 1'b0;
            frame_sync_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            load_pend_q  <= load_pend_d;
            load_ovf_q   <= load_i && load_pend_q && !apply;
            frame_sync_q <= play && (cnt_q == '0);
            if (stage) len_shd_q <= pat_len_i;
            if (apply) len_act_q <= len_shd_q;

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (en_i) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_q <= wrap ? '0 : cnt_q + CW'(1);
                    // Dropping en on the wrap edge ends cleanly: no new frame starts.
                    if (!en_i) begin
                        state_q   <= wrap ? ST_IDLE : ST_STOP;
                        running_q <= 1'b0;
                    end
                end
                ST_STOP: begin
                    cnt_q <= wrap ? '0 : cnt_q + CW'(1);
                    if (en_i) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (wrap) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        pattern_lane #(.PAT_W(PAT_W)) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .stage_i   (stage),
            .apply_i   (apply),
            .play_i    (play),
            .pat_i     (pat_in_i[c*PAT_W +: PAT_W]),
            .cnt_i     (cnt_q),
            .gen_clk_o (gen_clk_o[c])
        );
    end

    assign frame_sync_o = frame_sync_q;
    assign load_pend_o  = load_pend_q;
    assign load_ovf_o   = load_ovf_q;
    assign running_o    = running_q;

endmodule

// File: tb/tb_clk_pattern_gen.sv
module tb_clk_pattern_gen;

    logic        clk;
    logic        rstn;
    logic        en_i;
    logic        load_i;
    logic [31:0] pat_in_i;
    logic [3:0]  pat_len_i;
    logic [1:0]  gen_clk_o;
    logic        frame_sync_o;
    logic        load_pend_o;
    logic        load_ovf_o;
    logic        running_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] pa, pb, pc0, pc1;

    clk_pattern_gen #(.N_CH(2), .PAT_W(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en_i         (en_i),
        .load_i       (load_i),
        .pat_in_i     (pat_in_i),
        .pat_len_i    (pat_len_i),
        .gen_clk_o    (gen_clk_o),
        .frame_sync_o (frame_sync_o),
        .load_pend_o  (load_pend_o),
        .load_ovf_o   (load_ovf_o),
        .running_o    (running_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pa  = 16'hAAAA;
        pb  = 16'h00FF;
        pc0 = 16'h0003;
        pc1 = 16'h0005;
        rstn = 1'b0; en_i = 1'b0; load_i = 1'b0; pat_in_i = '0; pat_len_i = '0;
        step(); step();
        chk("rst gen", gen_clk_o, 2'b00);
        chk("rst fs", frame_sync_o, 1'b0);
        chk("rst pend", load_pend_o, 1'b0);
        chk("rst ovf", load_ovf_o, 1'b0);
        chk("rst run", running_o, 1'b0);

        // Stage AAAA / 00FF, length 16, then start.
        rstn = 1'b1; load_i = 1'b1; pat_in_i = {pb, pa}; pat_len_i = 4'd15;
        step();
        chk("idle pend set", load_pend_o, 1'b1);
        chk("idle run", running_o, 1'b0);
        load_i = 1'b0; en_i = 1'b1;
        step();
        chk("start run", running_o, 1'b1);
        chk("start pend clr", load_pend_o, 1'b0);
        chk("start gen", gen_clk_o, 2'b00);
        chk("start fs", frame_sync_o, 1'b0);
        step();

        // Frame 1.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("f1 gen b%0d", k), gen_clk_o, {pb[k], pa[k]});
            chk($sformatf("f1 fs b%0d", k), frame_sync_o, (k == 0));
            step();
        end

        // Frame 2: stage 4-bit pattern mid-frame, then an overflowing load.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("f2 gen b%0d", k), gen_clk_o, {pb[k], pa[k]});
            chk($sformatf("f2 fs b%0d", k), frame_sync_o, (k == 0));
            if (k == 2) begin
                load_i = 1'b1; pat_in_i = {pc1, pc0}; pat_len_i = 4'd3;
            end
            if (k == 3) begin
                chk("mid pend", load_pend_o, 1'b1);
                load_i = 1'b1; pat_in_i = {16'h0000, 16'h000F}; pat_len_i = 4'd1;
            end
            if (k == 4) begin
                chk("ovf pulse", load_ovf_o, 1'b1);
                load_i = 1'b0;
            end
            if (k == 5) chk("ovf single", load_ovf_o, 1'b0);
            if (k == 14) chk("pend before wrap", load_pend_o, 1'b1);
            if (k == 15) chk("pend after wrap", load_pend_o, 1'b0);
            step();
        end

        // Two 4-cycle frames of the first staged pattern.
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("s gen c%0d", k), gen_clk_o, {pc1[k%4], pc0[k%4]});
            chk($sformatf("s fs c%0d", k), frame_sync_o, ((k % 4) == 0));
            step();
        end

        // Third short frame: restage the 16-bit pattern.
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s3 gen b%0d", k), gen_clk_o, {pc1[k], pc0[k]});
            if (k == 0) begin
                load_i = 1'b1; pat_in_i = {pb, pa}; pat_len_i = 4'd15;
            end
            if (k == 1) begin
                load_i = 1'b0;
                chk("s3 pend", load_pend_o, 1'b1);
            end
            if (k == 3) chk("s3 pend clr", load_pend_o, 1'b0);
            step();
        end

        // 16-bit frame with en dropped at cnt=5: the frame is still completed.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("stop gen b%0d", k), gen_clk_o, {pb[k], pa[k]});
            chk($sformatf("stop fs b%0d", k), frame_sync_o, (k == 0));
            if (k == 4) en_i = 1'b0;
            if (k == 5) chk("stop run", running_o, 1'b0);
            step();
        end
        chk("idle gen0", gen_clk_o, 2'b00);
        chk("idle fs0", frame_sync_o, 1'b0);
        chk("idle run0", running_o, 1'b0);
        step();
        chk("idle gen1", gen_clk_o, 2'b00);

        // Restart, then drop and re-assert en inside one frame.
        en_i = 1'b1;
        step();
        chk("restart run", running_o, 1'b1);
        chk("restart gen", gen_clk_o, 2'b00);
        step();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rs gen b%0d", k), gen_clk_o, {pb[k], pa[k]});
            chk($sformatf("rs fs b%0d", k), frame_sync_o, (k == 0));
            if (k == 4) en_i = 1'b0;
            if (k == 5) chk("rs stop", running_o, 1'b0);
            if (k == 8) en_i = 1'b1;
            if (k == 9) chk("rs resume", running_o, 1'b1);
            step();
        end
        chk("nogap gen b0", gen_clk_o, {pb[0], pa[0]});
        chk("nogap fs b0", frame_sync_o, 1'b1);
        step();
        chk("nogap gen b1", gen_clk_o, {pb[1], pa[1]});
        step();

        // Stage a length-1 frame of all ones.
        for (int k = 2; k < 16; k++) begin
            chk($sformatf("l0 gen b%0d", k), gen_clk_o, {pb[k], pa[k]});
            if (k == 2) begin
                load_i = 1'b1; pat_in_i = {16'h0001, 16'h0001}; pat_len_i = 4'd0;
            end
            if (k == 3) load_i = 1'b0;
            step();
        end
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("len0 gen %0d", k), gen_clk_o, 2'b11);
            chk($sformatf("len0 fs %0d", k), frame_sync_o, 1'b1);
            step();
        end

        // Asynchronous reset mid-frame, checked before the next rising edge.
        #2 rstn = 1'b0;
        #1;
        chk("arst gen", gen_clk_o, 2'b00);
        chk("arst fs", frame_sync_o, 1'b0);
        chk("arst run", running_o, 1'b0);
        en_i = 1'b0;
        step();
        rstn = 1'b1;
        step();
        chk("post rst run", running_o, 1'b0);
        chk("post rst gen", gen_clk_o, 2'b00);
        chk("post rst pend", load_pend_o, 1'b0);
        en_i = 1'b1;
        step();
        chk("post rst start", running_o, 1'b1);
        step();
        // Zero pattern with the default 16-cycle period.
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("zero gen %0d", k), gen_clk_o, 2'b00);
            chk($sformatf("zero fs %0d", k), frame_sync_o, (k == 0 || k == 16));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
